// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared definitions for the fuzzy controller input sequencer.
//   DATA_W     controller input/output width
//   FZ_MIN_IN  lowest legal controller input
//   FZ_MAX_IN  highest legal controller input
//   fz_state_t sequencer states
package fuzzy_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FZ_MIN_IN = 1;
    localparam int unsigned FZ_MAX_IN = 254;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OUT
    } fz_state_t;

endpackage

// File: rtl/fuzzy_in_sequencer_if.sv
// fuzzy_in_sequencer_if: sample-in and result-out valid/ready streams.
//   in_valid/in_ready/in_e1/in_e2   raw sample pair stream
//   out_valid/out_ready/out_data    captured result stream
// Modports: master = upstream/downstream side, slave = sequencer side.
interface fuzzy_in_sequencer_if
    import fuzzy_pkg::*;
#(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned DATA_W = fuzzy_pkg::DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_e1;
    logic [IN_W-1:0]   in_e2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_e1, in_e2, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_e1, in_e2, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fuzzy_in_clamp.sv
// fuzzy_in_clamp: combinational saturator into [FZ_MIN_IN, FZ_MAX_IN].
//   i_v        raw unsigned input, IN_W bits
//   o_v        saturated value, DATA_W bits
//   o_clamped  high when the input was outside the legal range
module fuzzy_in_clamp
    import fuzzy_pkg::*;
#(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned DATA_W = fuzzy_pkg::DATA_W
)(
    input  logic [IN_W-1:0]   i_v,
    output logic [DATA_W-1:0] o_v,
    output logic              o_clamped
);

    always_comb begin
        o_v       = DATA_W'(i_v);
        o_clamped = 1'b0;
        if (i_v < IN_W'(FZ_MIN_IN)) begin
            o_v       = DATA_W'(FZ_MIN_IN);
            o_clamped = 1'b1;
        end else if (i_v > IN_W'(FZ_MAX_IN)) begin
            o_v       = DATA_W'(FZ_MAX_IN);
            o_clamped = 1'b1;
        end
    end

endmodule

// File: rtl/fuzzy_in_sequencer.sv
// fuzzy_in_sequencer: feeds clamped sample pairs to the type-2 trapezoidal
// fuzzy controller, holds them for HOLD_CYCLES, then captures the crisp
// output and offers it downstream.
//   clk_0, Srst            clock (rising edge), async active-high reset
//   bus (slave)            sample-in and result-out valid/ready streams
//   Entrada_01/02          clamped controller inputs
//   EN_REGRAS              rule-evaluation enable, high during HOLD
//   saida_defuzzy          controller crisp output
//   busy                   high in HOLD and OUT
//   clamp_count            (only with FUZZY_CLAMP_STATS_EN) saturating count
//                          of accepted samples that needed clamping
module fuzzy_in_sequencer
    import fuzzy_pkg::*;
#(
    parameter int unsigned IN_W        = 9,
    parameter int unsigned DATA_W      = fuzzy_pkg::DATA_W,
    parameter int unsigned HOLD_CYCLES = 28
)(
    input  logic                clk_0,
    input  logic                Srst,
    fuzzy_in_sequencer_if.slave bus,
    output logic [DATA_W-1:0]   Entrada_01,
    output logic [DATA_W-1:0]   Entrada_02,
    output logic                EN_REGRAS,
    input  logic [DATA_W-1:0]   saida_defuzzy,
    output logic                busy
`ifdef FUZZY_CLAMP_STATS_EN
    ,
    output logic [15:0]         clamp_count
`endif
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1) begin : g_hold_check
        $error("fuzzy_in_sequencer: HOLD_CYCLES must be >= 1");
    end

    fz_state_t         r_state;
    fz_state_t         w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_e1;
    logic [DATA_W-1:0] r_e2;
    logic              r_en;
    logic              w_accept;
    logic              w_capture;
    logic              w_release;
    logic [DATA_W-1:0] w_c1;
    logic [DATA_W-1:0] w_c2;
    logic              w_clamp1;
    logic              w_clamp2;

    fuzzy_in_clamp #(.IN_W(IN_W), .DATA_W(DATA_W)) u_clamp1 (
        .i_v       (bus.in_e1),
        .o_v       (w_c1),
        .o_clamped (w_clamp1)
    );

    fuzzy_in_clamp #(.IN_W(IN_W), .DATA_W(DATA_W)) u_clamp2 (
        .i_v       (bus.in_e2),
        .o_v       (w_c2),
        .o_clamped (w_clamp2)
    );

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: if (bus.in_valid) begin
                w_accept = 1'b1;
                w_next   = HOLD;
            end
            HOLD: if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                w_capture = 1'b1;
                w_next    = OUT;
            end
            OUT: if (bus.out_ready) begin
                w_release = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Counter may reach HOLD_CYCLES on the capture edge; CNT_W covers it.
    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            r_e1        <= DATA_W'(FZ_MIN_IN);
            r_e2        <= DATA_W'(FZ_MIN_IN);
            r_en        <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_e1  <= w_c1;
                r_e2  <= w_c2;
                r_en  <= 1'b1;
                r_cnt <= '0;
            end else if (r_state == HOLD) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_out_data  <= saida_defuzzy;
                r_out_valid <= 1'b1;
                r_en        <= 1'b0;
            end
            if (w_release) r_out_valid <= 1'b0;
        end
    end

`ifdef FUZZY_CLAMP_STATS_EN
    logic [15:0] r_clamp_count;

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            r_clamp_count <= '0;
        end else if (w_accept && (w_clamp1 || w_clamp2) && (r_clamp_count != '1)) begin
            r_clamp_count <= r_clamp_count + 16'd1;
        end
    end

    assign clamp_count = r_clamp_count;
`else
    logic w_unused_clamp;
    assign w_unused_clamp = w_clamp1 ^ w_clamp2;
`endif

    // in_ready is held low while Srst is asserted, even though state is IDLE.
    assign bus.in_ready  = (r_state == IDLE) && !Srst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign Entrada_01    = r_e1;
    assign Entrada_02    = r_e2;
    assign EN_REGRAS     = r_en;
    assign busy          = (r_state != IDLE);

endmodule
